// File: rtl/adder_bist_pkg.sv
// Shared types, constants and the golden-sum reference used by the adder BIST engine.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    // Constants for the default 4-bit adder family.
    localparam int DEF_WIDTH = 4;
    localparam int NVEC      = 2 ** (2 * DEF_WIDTH + 1);
    localparam int CNT_W     = 2 * DEF_WIDTH + 2;

    // Widest operand golden_sum can model; narrower operands are zero-extended into it.
    localparam int MAX_WIDTH = 16;

    // Unsigned a+b+cin with a carry bit kept, so nothing is truncated.
    function automatic logic [MAX_WIDTH:0] golden_sum(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Bus between the BIST engine (master) and the adder under test (slave).
interface adder_bist_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Cout;
    logic [WIDTH-1:0] S;

    modport master (output A, output B, output Cin, input Cout, input S);
    modport slave  (input A, input B, input Cin, output Cout, output S);
endinterface

// File: rtl/adder_bist_vec_gen.sv
// Exhaustive {A,B,Cin} vector counter plus the per-vector settle counter.
module bist_vec_gen #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic             hold,
    output logic [2*WIDTH:0] vec,
    output logic             settle_done,
    output logic             last
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE - 1);

    logic [SW-1:0] settle_cnt;

    // Vector register: cleared when a run is launched, stepped once per checked vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
        end else if (load) begin
            vec <= '0;
        end else if (advance) begin
            vec <= vec + 1'b1;
        end
    end

    // Settle counter: restarts with every new vector and stops at its terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (load || advance) begin
            settle_cnt <= '0;
        end else if (hold && !settle_done) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign settle_done = (settle_cnt == SETTLE_MAX);
    assign last        = &vec;

endmodule

// File: rtl/adder_bist.sv
// BIST engine: sweeps all adder input vectors, counts mismatches and captures the first one.
module adder_bist
    import adder_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    adder_bist_if.master         bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     first_fail
);

    bist_state_t      state;
    bist_state_t      next_state;
    logic [2*WIDTH:0] vec;
    logic             settle_done;
    logic             last;
    logic             load;
    logic             advance;
    logic             hold;
    logic             mismatch;
    logic [MAX_WIDTH:0] golden;

    bist_vec_gen #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
    ) u_vec_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .advance     (advance),
        .hold        (hold),
        .vec         (vec),
        .settle_done (settle_done),
        .last        (last)
    );

    assign bus.A   = vec[2*WIDTH:WIDTH+1];
    assign bus.B   = vec[WIDTH:1];
    assign bus.Cin = vec[0];

    // Reference sum is computed at full width so a dropped carry shows up as a mismatch.
    assign golden   = golden_sum(MAX_WIDTH'(bus.A), MAX_WIDTH'(bus.B), bus.Cin);
    assign mismatch = (golden != (MAX_WIDTH + 1)'({bus.Cout, bus.S}));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only looked at while idle or finished.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = DRIVE;
            DRIVE:   if (settle_done) next_state = CHECK;
            CHECK:   next_state = last ? DONE : DRIVE;
            DONE:    if (start) next_state = DRIVE;
            default: next_state = IDLE;
        endcase
    end

    // Control and status outputs decoded from the current state.
    always_comb begin
        load    = 1'b0;
        advance = 1'b0;
        hold    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE:    load = start;
            DRIVE: begin
                hold = 1'b1;
                busy = 1'b1;
            end
            CHECK: begin
                advance = !last;
                busy    = 1'b1;
            end
            DONE: begin
                load = start;
                done = 1'b1;
            end
            default: ;
        endcase
        pass = done && (err_count == '0);
    end

    // Error counter and first-failure capture; a new run wipes the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            first_fail <= '0;
        end else if (load) begin
            err_count  <= '0;
            first_fail <= '0;
        end else if (state == CHECK && mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) begin
                first_fail <= vec;
            end
        end
    end

endmodule
